// File: rtl/bitrev_rd_fifo.sv
// Ping-pong reorder buffer that takes samples in natural order and returns them in bit-reversed order.
// Two RAM banks alternate between filling and draining; each bank keeps the frame length it latched.
//
//  state       | meaning
//  ------------+-----------------------------------------------
//  ST_EMPTY    | bank holds no data, next push starts a frame
//  ST_FILLING  | frame partially written, more pushes expected
//  ST_READY    | frame complete, waiting for its first pop
//  ST_DRAINING | frame partially read out in bit-reversed order
module bitrev_rd_fifo #(
    parameter int DATA_WIDTH = 32,
    parameter int MAX_POINT  = 64,
    parameter bit FULL       = 1'b1,
    parameter bit EMPTY      = 1'b1,
    localparam int LOG_MAX   = $clog2(MAX_POINT),
    localparam int PW        = $clog2(LOG_MAX + 1)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [PW-1:0]         point,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  push,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  valid,
    output logic                  last,
    output logic                  full,
    output logic                  empty,
    output logic                  clean_bank
);

    typedef enum logic [1:0] {
        ST_EMPTY    = 2'd0,
        ST_FILLING  = 2'd1,
        ST_READY    = 2'd2,
        ST_DRAINING = 2'd3
    } bank_state_t;

    bank_state_t           state_q [2];
    bank_state_t           state_d [2];
    logic [PW-1:0]         pt_q    [2];
    logic                  wr_bank;
    logic                  rd_bank;
    logic [LOG_MAX-1:0]    wr_cnt;
    logic [LOG_MAX-1:0]    rd_cnt;
    logic [DATA_WIDTH-1:0] mem0    [MAX_POINT];
    logic [DATA_WIDTH-1:0] mem1    [MAX_POINT];
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  valid_q;
    logic                  last_q;
    logic                  clean_q;

    bank_state_t           wr_state;
    bank_state_t           rd_state;
    logic                  wr_open;
    logic                  rd_open;
    logic                  push_acc;
    logic                  pop_acc;
    logic [PW-1:0]         wr_pt;
    logic                  wr_done;
    logic                  rd_done;
    logic [LOG_MAX-1:0]    rd_addr;

    function automatic logic [LOG_MAX-1:0] last_index(input logic [PW-1:0] p);
        logic [LOG_MAX:0] n;
        n = (LOG_MAX + 1)'(1) << p;
        return LOG_MAX'(n - (LOG_MAX + 1)'(1));
    endfunction

    // Reverse all LOG_MAX bits, then shift down so only the low p bits are mirrored.
    function automatic logic [LOG_MAX-1:0] rev_addr(input logic [LOG_MAX-1:0] cnt,
                                                    input logic [PW-1:0] p);
        logic [LOG_MAX-1:0] r;
        for (int i = 0; i < LOG_MAX; i++) begin
            r[i] = cnt[LOG_MAX-1-i];
        end
        return r >> (PW'(LOG_MAX) - p);
    endfunction

    always_comb begin
        wr_state = state_q[wr_bank];
        rd_state = state_q[rd_bank];
        wr_open  = (wr_state == ST_EMPTY) || (wr_state == ST_FILLING);
        rd_open  = (rd_state == ST_READY) || (rd_state == ST_DRAINING);
        push_acc = push && wr_open;
        pop_acc  = pop && rd_open;
        wr_pt    = (wr_state == ST_EMPTY) ? point : pt_q[wr_bank];
        wr_done  = push_acc && (wr_cnt == last_index(wr_pt));
        rd_done  = pop_acc && (rd_cnt == last_index(pt_q[rd_bank]));
        rd_addr  = rev_addr(rd_cnt, pt_q[rd_bank]);
    end

    // wr_bank and rd_bank never share a bank while both are open, so both updates may apply.
    always_comb begin
        for (int b = 0; b < 2; b++) begin
            state_d[b] = state_q[b];
            if (push_acc && (wr_bank == 1'(b))) begin
                state_d[b] = wr_done ? ST_READY : ST_FILLING;
            end
            if (pop_acc && (rd_bank == 1'(b))) begin
                state_d[b] = rd_done ? ST_EMPTY : ST_DRAINING;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int b = 0; b < 2; b++) begin
                state_q[b] <= ST_EMPTY;
                pt_q[b]    <= '0;
            end
            wr_bank <= 1'b0;
            rd_bank <= 1'b0;
            wr_cnt  <= '0;
            rd_cnt  <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            clean_q <= 1'b0;
        end else begin
            for (int b = 0; b < 2; b++) begin
                state_q[b] <= state_d[b];
            end
            if (push_acc && (wr_state == ST_EMPTY)) begin
                pt_q[wr_bank] <= point;
            end
            if (push_acc) begin
                wr_cnt <= wr_done ? '0 : wr_cnt + 1'b1;
            end
            if (wr_done) begin
                wr_bank <= ~wr_bank;
            end
            if (pop_acc) begin
                rd_cnt <= rd_done ? '0 : rd_cnt + 1'b1;
            end
            if (rd_done) begin
                rd_bank <= ~rd_bank;
            end
            valid_q <= pop_acc;
            last_q  <= rd_done;
            clean_q <= rd_done;
        end
    end

    always_ff @(posedge clk) begin
        if (push_acc) begin
            if (wr_bank) begin
                mem1[wr_cnt] <= data_in;
            end else begin
                mem0[wr_cnt] <= data_in;
            end
        end
        if (pop_acc) begin
            rd_data <= rd_bank ? mem1[rd_addr] : mem0[rd_addr];
        end
    end

    assign data_out   = valid_q ? rd_data : '0;
    assign valid      = valid_q;
    assign last       = last_q;
    assign clean_bank = clean_q;
    assign full       = FULL ? !wr_open : 1'b0;
    assign empty      = EMPTY ? !rd_open : 1'b0;

endmodule

// File: tb/tb_bitrev_rd_fifo.sv
// Scoreboard bench for bitrev_rd_fifo: a frame-level queue model predicts every output sample,
// and a negedge monitor compares two builds (flags driven / flags tied off) against it.
module tb_bitrev_rd_fifo;
    localparam int DW   = 32;
    localparam int MAXP = 64;
    localparam int PW   = 3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [PW-1:0] point = 3'd3;
    logic [DW-1:0] data_in = '0;
    logic          push = 1'b0;
    logic          pop = 1'b0;

    logic [DW-1:0] data_a, data_b;
    logic          valid_a, valid_b, last_a, last_b;
    logic          full_a, full_b, empty_a, empty_b, clean_a, clean_b;

    always #5 clk = ~clk;

    bitrev_rd_fifo #(.DATA_WIDTH(DW), .MAX_POINT(MAXP), .FULL(1'b1), .EMPTY(1'b1)) dut_a (
        .clk(clk), .rst_n(rst_n), .point(point), .data_in(data_in), .push(push), .pop(pop),
        .data_out(data_a), .valid(valid_a), .last(last_a), .full(full_a), .empty(empty_a),
        .clean_bank(clean_a));

    bitrev_rd_fifo #(.DATA_WIDTH(DW), .MAX_POINT(MAXP), .FULL(1'b0), .EMPTY(1'b0)) dut_b (
        .clk(clk), .rst_n(rst_n), .point(point), .data_in(data_in), .push(push), .pop(pop),
        .data_out(data_b), .valid(valid_b), .last(last_b), .full(full_b), .empty(empty_b),
        .clean_bank(clean_b));

    typedef struct {
        logic [DW-1:0] data;
        bit            last;
    } entry_t;

    entry_t        ready_q[$];
    entry_t        exp_q[$];
    logic [DW-1:0] fill_q[$];
    int            fill_len = 0;
    int            n_frames = 0;
    bit            exp_valid = 1'b0;
    int            n_vec = 0;
    int            n_fail = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_vec++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    // Frame-level model: at most two complete frames buffered, frames leave in arrival order.
    task automatic model_edge();
        bit     pa, qa;
        entry_t e;
        if (!rst_n) begin
            exp_valid = 1'b0;
            return;
        end
        pa = push && (n_frames < 2);
        qa = pop && (n_frames >= 1);
        exp_valid = qa;
        if (qa) begin
            e = ready_q.pop_front();
            exp_q.push_back(e);
            if (e.last) n_frames--;
        end
        if (pa) begin
            if (fill_q.size() == 0) fill_len = 1 << point;
            fill_q.push_back(data_in);
            if (fill_q.size() == fill_len) begin
                int lg;
                lg = $clog2(fill_len);
                for (int i = 0; i < fill_len; i++) begin
                    int r;
                    r = 0;
                    for (int k = 0; k < lg; k++) r = r * 2 + ((i >> k) & 1);
                    e.data = fill_q[r];
                    e.last = (i == fill_len - 1);
                    ready_q.push_back(e);
                end
                fill_q.delete();
                n_frames++;
            end
        end
    endtask

    task automatic model_reset();
        ready_q.delete();
        exp_q.delete();
        fill_q.delete();
        n_frames  = 0;
        exp_valid = 1'b0;
    endtask

    task automatic cyc(input bit p, input bit q, input logic [DW-1:0] d);
        push    = p;
        pop     = q;
        data_in = d;
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while ((n_frames > 0) && (guard < 200)) begin
            cyc(1'b0, 1'b1, '0);
            guard++;
        end
        check("drain_budget", 64'(n_frames), 64'd0);
        cyc(1'b0, 1'b0, '0);
        cyc(1'b0, 1'b0, '0);
    endtask

    always @(negedge clk) begin
        entry_t e;
        check("valid", valid_a, exp_valid);
        check("valid_b", valid_b, exp_valid);
        check("full", full_a, n_frames == 2);
        check("empty", empty_a, n_frames == 0);
        check("full_tied", full_b, 1'b0);
        check("empty_tied", empty_b, 1'b0);
        if (valid_a) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_fail++;
                $display("FAIL unexpected_valid: actual=1 required=0 at %0t", $time);
            end else begin
                e = exp_q.pop_front();
                check("data", data_a, e.data);
                check("data_b", data_b, e.data);
                check("last", last_a, e.last);
                check("last_b", last_b, e.last);
                check("clean_bank", clean_a, e.last);
            end
        end else begin
            check("idle_data", data_a, '0);
            check("idle_last", last_a, 1'b0);
            check("idle_clean", clean_a, 1'b0);
        end
    end

    initial begin
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        cyc(1'b0, 1'b0, '0);

        // single frame, N = 8
        point = 3'd3;
        for (int i = 0; i < 8; i++) cyc(1'b1, 1'b0, DW'(i));
        for (int i = 0; i < 8; i++) cyc(1'b0, 1'b1, '0);
        cyc(1'b0, 1'b0, '0);

        // fill both banks, N = 4, ninth push dropped
        point = 3'd2;
        for (int i = 0; i < 9; i++) cyc(1'b1, 1'b0, DW'(i));
        for (int i = 0; i < 10; i++) cyc(1'b0, 1'b1, '0);

        // streaming with pop held high throughout
        point = 3'd3;
        for (int i = 0; i < 32; i++) cyc(1'b1, 1'b1, DW'(100 + i));
        drain();

        // point changed mid-frame is ignored
        point = 3'd3;
        for (int i = 0; i < 4; i++) cyc(1'b1, 1'b0, DW'(200 + i));
        point = 3'd1;
        for (int i = 4; i < 8; i++) cyc(1'b1, 1'b0, DW'(200 + i));
        drain();

        // extremes: N = 64 and N = 2
        point = 3'd6;
        for (int i = 0; i < 64; i++) cyc(1'b1, 1'b0, DW'(300 + i));
        drain();
        point = 3'd1;
        for (int i = 0; i < 2; i++) cyc(1'b1, 1'b0, DW'(400 + i));
        drain();

        // pop on empty, then reset in the middle of a frame
        cyc(1'b0, 1'b1, '0);
        cyc(1'b0, 1'b1, '0);
        point = 3'd3;
        for (int i = 0; i < 5; i++) cyc(1'b1, 1'b0, DW'(500 + i));
        rst_n = 1'b0;
        model_reset();
        cyc(1'b0, 1'b0, '0);
        cyc(1'b0, 1'b0, '0);
        rst_n = 1'b1;
        cyc(1'b0, 1'b0, '0);
        for (int i = 0; i < 8; i++) cyc(1'b1, 1'b0, DW'(600 + i));
        drain();

        // random traffic with random point changes
        for (int i = 0; i < 2500; i++) begin
            if ($urandom_range(0, 15) == 0) point = PW'($urandom_range(1, 6));
            cyc($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0, DW'($urandom));
        end
        drain();

        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule
